// File: rtl/resv_issue_ctrl.sv
// Reservation-station issue controller: oldest-first per-pipe pick, round-robin between pipes, insert/shift addressing.
// Latency: issue and insert decisions are combinational in the cycle the candidates appear; occupancy updates at the next edge.
// Backpressure: dec_ready drops when full, during flush and during the clear cycle; no same-cycle full bypass.
// Optional build macro RESV_ISSUE_CTRL_STAT_EN adds per-pipe issue counters (stat_iss0/stat_iss1).
module resv_issue_ctrl #(
    parameter int W_ident = 4,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       dec_valid,
    output logic                       dec_ready,
    input  logic [DEPTH*W_ident-1:0]   cand0_bus,
    input  logic [DEPTH*W_ident-1:0]   cand1_bus,
    input  logic                       ex0_ready,
    input  logic                       ex1_ready,
    output logic                       iss_valid,
    output logic                       iss_pip,
    output logic [W_ident-1:0]         iss_idx,
    output logic [W_ident-1:0]         addr_insert,
    output logic [W_ident-1:0]         addr_shift,
    output logic                       rs_clear,
`ifdef RESV_ISSUE_CTRL_STAT_EN
    output logic [31:0]                stat_iss0,
    output logic [31:0]                stat_iss1,
`endif
    output logic [W_ident-1:0]         occ
);

    localparam logic [W_ident-1:0] NO_CELL = '1;
    localparam logic [W_ident-1:0] FULL    = W_ident'(DEPTH);

    logic [W_ident-1:0] occ_q;
    logic               rr_q;
    logic               init_q;

    logic               found0, found1;
    logic [W_ident-1:0] sel0, sel1;
    logic               has0, has1;
    logic               both;
    logic               insert;

    // Lowest-positioned slice naming a live cell wins; the pick carries the cell address it names.
    function automatic logic [W_ident:0] pick(input logic [DEPTH*W_ident-1:0] bus,
                                              input logic [W_ident-1:0] lim);
        logic [W_ident:0]   res;
        logic [W_ident-1:0] slice;
        res = {1'b0, NO_CELL};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            slice = bus[i*W_ident +: W_ident];
            if (slice != NO_CELL && slice < lim) begin
                res = {1'b1, slice};
            end
        end
        return res;
    endfunction

    // Reset low, the post-reset init cycle and flush all clear the cells.
    assign rs_clear = !rst_n || init_q || flush;

    assign {found0, sel0} = pick(cand0_bus, occ_q);
    assign {found1, sel1} = pick(cand1_bus, occ_q);
    assign has0 = found0 && ex0_ready;
    assign has1 = found1 && ex1_ready;

    // Arbitrate between the pipes: single requester wins, rr breaks ties; nothing issues while clearing.
    always_comb begin
        iss_valid = 1'b0;
        iss_pip   = 1'b0;
        iss_idx   = NO_CELL;
        both      = 1'b0;
        if (!rs_clear) begin
            if (has0 && has1) begin
                both      = 1'b1;
                iss_valid = 1'b1;
                iss_pip   = rr_q;
                iss_idx   = rr_q ? sel1 : sel0;
            end else if (has0) begin
                iss_valid = 1'b1;
                iss_idx   = sel0;
            end else if (has1) begin
                iss_valid = 1'b1;
                iss_pip   = 1'b1;
                iss_idx   = sel1;
            end
        end
    end

    assign addr_shift = iss_valid ? iss_idx : NO_CELL;
    assign dec_ready  = (occ_q != FULL) && !rs_clear;
    assign insert     = dec_valid && dec_ready;

    // A same-cycle issue shifts the tail down by one, so the new entry lands one slot lower.
    always_comb begin
        addr_insert = NO_CELL;
        if (insert) begin
            addr_insert = iss_valid ? (occ_q - 1'b1) : occ_q;
        end
    end

    assign occ = occ_q;

    // Occupancy, round-robin flag and init flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            rr_q   <= 1'b0;
            init_q <= 1'b1;
        end else begin
            init_q <= 1'b0;
            if (flush) begin
                occ_q <= '0;
                rr_q  <= 1'b0;
            end else begin
                occ_q <= occ_q + W_ident'(insert) - W_ident'(iss_valid);
                if (both) begin
                    rr_q <= ~rr_q;
                end
            end
        end
    end

`ifdef RESV_ISSUE_CTRL_STAT_EN
    // Per-pipe issue counters; wrap naturally and survive flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_iss0 <= '0;
            stat_iss1 <= '0;
        end else if (iss_valid) begin
            if (iss_pip) begin
                stat_iss1 <= stat_iss1 + 32'd1;
            end else begin
                stat_iss0 <= stat_iss0 + 32'd1;
            end
        end
    end
`endif

endmodule
